mc_alu: RTL and testbench

- Multi-cycle 8-bit ALU of the MCU datapath. It sits directly upstream of the carry flag register and drives its load/data inputs.
- It takes the current carry flag back as carry-in, runs one operation per START, and reports completion with a one-cycle DONE pulse.
- Its C_LD/C_OUT and Z_LD/Z_OUT outputs wire straight to the flag registers' LD/IN pins.
- Iterative multiply is compiled in optionally.

---
 rtl/mc_alu.sv | 278 +++++++++++++++++++++++++++
 tb/tb_mc_alu.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_alu.sv
// ---------------------------------------------------------------------------
// mc_alu -- multi-cycle 8-bit ALU for the MCU datapath.
//
// One operation runs per accepted start request. Its completion is reported by
// a one-cycle done pulse. The carry/zero load strobes and data outputs drive
// the flag registers directly. The current carry flag value is fed back in
// through c_in_i.
//
// Optional feature macro: MC_ALU_MUL_EN
//   defined   : iterative shift-add multiply (op 12) is built. It takes WIDTH
//               MUL cycles, then FIN.
//   undefined : no MUL state or hardware. Op 12 is illegal and result_hi_o is
//               tied to 0.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   start_i      request, sampled only in IDLE
//   op_i[3:0]    operation code, captured with start
//   a_i, b_i     operands, captured with start
//   c_in_i       current carry flag, captured with start
//   busy_o       high whenever the FSM is not IDLE
//   done_o       one-cycle completion pulse (FIN state)
//   result_o     result, or low half of the product. Holds until next completion
//   result_hi_o  high half of the product. 0 for all other ops
//   c_out_o      new carry value
//   c_ld_o       carry flag load strobe (with done, legal ops only)
//   z_out_o      new zero value
//   z_ld_o       zero flag load strobe (with done, legal ops only)
// ---------------------------------------------------------------------------
module mc_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             c_out_o,
  output logic             c_ld_o,
  output logic             z_out_o,
  output logic             z_ld_o
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_LSL  = 4'd7;
  localparam logic [3:0] OP_LSR  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_ASR  = 4'd11;
`ifdef MC_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
`ifdef MC_ALU_MUL_EN
    S_MUL  = 2'd2,
`endif
    S_FIN  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             ld_q, ld_d;
`ifdef MC_ALU_MUL_EN
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // partial product (upper half)
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_lo;
`endif

  // Single-cycle datapath, evaluated from the captured operands during EXEC.
  logic [WIDTH:0]   ext_a, ext_b, ext_c;
  logic [WIDTH:0]   exec_sum;
  logic [WIDTH-1:0] exec_r;
  logic             exec_c;
  logic             exec_legal;

  assign ext_a = {1'b0, a_q};
  assign ext_b = {1'b0, b_q};
  assign ext_c = {{WIDTH{1'b0}}, cin_q};

  always_comb begin
    exec_sum   = '0;
    exec_r     = '0;
    exec_c     = 1'b0;
    exec_legal = 1'b1;
    case (op_q)
      OP_ADD: begin
        exec_sum = ext_a + ext_b;
        exec_r   = exec_sum[WIDTH-1:0];
        exec_c   = exec_sum[WIDTH];
      end
      OP_ADDC: begin
        exec_sum = ext_a + ext_b + ext_c;
        exec_r   = exec_sum[WIDTH-1:0];
        exec_c   = exec_sum[WIDTH];
      end
      // Subtraction is done one bit wider. The extra top bit is set exactly
      // when the true difference is negative, so it is the borrow.
      OP_SUB: begin
        exec_sum = ext_a - ext_b;
        exec_r   = exec_sum[WIDTH-1:0];
        exec_c   = exec_sum[WIDTH];
      end
      OP_SUBC: begin
        exec_sum = ext_a - ext_b - ext_c;
        exec_r   = exec_sum[WIDTH-1:0];
        exec_c   = exec_sum[WIDTH];
      end
      OP_AND: exec_r = a_q & b_q;
      OP_OR:  exec_r = a_q | b_q;
      OP_XOR: exec_r = a_q ^ b_q;
      OP_LSL: begin
        exec_r = {a_q[WIDTH-2:0], cin_q};
        exec_c = a_q[WIDTH-1];
      end
      OP_LSR: begin
        exec_r = {cin_q, a_q[WIDTH-1:1]};
        exec_c = a_q[0];
      end
      OP_ROL: begin
        exec_r = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
        exec_c = a_q[WIDTH-1];
      end
      OP_ROR: begin
        exec_r = {a_q[0], a_q[WIDTH-1:1]};
        exec_c = a_q[0];
      end
      OP_ASR: begin
        exec_r = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        exec_c = a_q[0];
      end
      // Illegal codes still finish with a zero result. Their flag loads are
      // suppressed, so the controller never hangs on a bad opcode.
      default: exec_legal = 1'b0;
    endcase
  end

`ifdef MC_ALU_MUL_EN
  // One shift-add step. b_q doubles as the multiplier shift register. Product
  // bits shift into its top as multiplier bits leave at the bottom.
  assign mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_lo  = {mul_sum[0], b_q[WIDTH-1:1]};
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      result_q    <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      ld_q        <= 1'b0;
`ifdef MC_ALU_MUL_EN
      result_hi_q <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      result_q    <= result_d;
      c_q         <= c_d;
      z_q         <= z_d;
      ld_q        <= ld_d;
`ifdef MC_ALU_MUL_EN
      result_hi_q <= result_hi_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    result_d    = result_q;
    c_d         = c_q;
    z_d         = z_q;
    ld_d        = ld_q;
`ifdef MC_ALU_MUL_EN
    result_hi_d = result_hi_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d  = op_i;
          a_d   = a_i;
          b_d   = b_i;
          cin_d = c_in_i;
`ifdef MC_ALU_MUL_EN
          acc_d = '0;
          cnt_d = '0;
          if (op_i == OP_MUL) state_d = S_MUL;
          else
`endif
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d    = exec_r;
        c_d         = exec_c;
        z_d         = ~|exec_r;
        ld_d        = exec_legal;
`ifdef MC_ALU_MUL_EN
        result_hi_d = '0;
`endif
        state_d     = S_FIN;
      end
`ifdef MC_ALU_MUL_EN
      S_MUL: begin
        acc_d = mul_sum[WIDTH:1];
        b_d   = mul_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          result_d    = mul_lo;
          result_hi_d = mul_sum[WIDTH:1];
          c_d         = |mul_sum[WIDTH:1];
          z_d         = ~|{mul_sum[WIDTH:1], mul_lo};
          ld_d        = 1'b1;
          state_d     = S_FIN;
        end
      end
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_FIN);
  assign c_ld_o   = done_o & ld_q;
  assign z_ld_o   = done_o & ld_q;
  assign result_o = result_q;
  assign c_out_o  = c_q;
  assign z_out_o  = z_q;
`ifdef MC_ALU_MUL_EN
  assign result_hi_o = result_hi_q;
`else
  assign result_hi_o = '0;
`endif

endmodule

// File: tb/tb_mc_alu.sv
module tb_mc_alu;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy_o, done_o, c_out_o, c_ld_o, z_out_o, z_ld_o;
  logic [W-1:0] result_o, result_hi_o;

  mc_alu #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .c_in_i(cin), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .result_hi_o(result_hi_o), .c_out_o(c_out_o), .c_ld_o(c_ld_o),
    .z_out_o(z_out_o), .z_ld_o(z_ld_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  typedef struct packed {
    logic [31:0] r;
    logic [31:0] hi;
    logic        c;
    logic        z;
    logic        legal;
  } res_t;

  function automatic res_t model(input int o, input int x, input int y, input int ci);
    res_t m;
    int   s;
    m = '0;
    m.legal = 1'b1;
    case (o)
      0:  begin s = x + y;      m.r = s % M; m.c = (s >= M); end
      1:  begin s = x + y + ci; m.r = s % M; m.c = (s >= M); end
      2:  begin s = x - y;      m.r = (s + M) % M; m.c = (s < 0); end
      3:  begin s = x - y - ci; m.r = (s + 2*M) % M; m.c = (s < 0); end
      4:  m.r = x & y;
      5:  m.r = x | y;
      6:  m.r = x ^ y;
      7:  begin s = 2*x + ci; m.r = s % M; m.c = (s >= M); end
      8:  begin m.r = ci*(M/2) + x/2; m.c = x[0]; end
      9:  begin m.r = (2*x) % M + x/(M/2); m.c = (x >= M/2); end
      10: begin m.r = x/2 + (x%2)*(M/2); m.c = x[0]; end
      11: begin m.r = x/2 + ((x >= M/2) ? M/2 : 0); m.c = x[0]; end
`ifdef MC_ALU_MUL_EN
      12: begin
        s = x * y;
        m.r = s % M; m.hi = s / M; m.c = (s >= M); m.z = (s == 0);
        return m;
      end
`endif
      default: m.legal = 1'b0;
    endcase
    m.z = (m.r == 0);
    return m;
  endfunction

  function automatic int latency(input int o);
`ifdef MC_ALU_MUL_EN
    if (o == 12) return W + 1;
`endif
    return 2;
  endfunction

  // Countdown of busy cycles left. Outputs update on entry to the last one.
  int   m_rem;
  res_t m_pend, m_out;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_pend <= '0;
      m_out  <= '0;
    end else if (m_rem == 0) begin
      if (start) begin
        m_pend <= model(int'(op), int'(a), int'(b), int'(cin));
        m_rem  <= latency(int'(op));
      end
    end else begin
      if (m_rem == 2) m_out <= m_pend;
      m_rem <= m_rem - 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy",   int'(busy_o),      int'(m_rem != 0));
      chk("done",   int'(done_o),      int'(m_rem == 1));
      chk("c_ld",   int'(c_ld_o),      int'(m_rem == 1 && m_out.legal));
      chk("z_ld",   int'(z_ld_o),      int'(m_rem == 1 && m_out.legal));
      chk("result", int'(result_o),    int'(m_out.r));
      chk("res_hi", int'(result_hi_o), int'(m_out.hi));
      chk("c_out",  int'(c_out_o),     int'(m_out.c));
      chk("z_out",  int'(z_out_o),     int'(m_out.z));
    end
  end

  // ---------------- transaction driver ----------------
  int           obs_lat;
  bit           obs_done;
  int           obs_extra;
  logic [W-1:0] obs_r, obs_hi;
  logic         obs_c, obs_z, obs_cld, obs_zld, obs_ld_after;

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input bit interfere);
    int n;
    @(negedge clk);
    op = o; a = x; b = y; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    obs_done = 1'b0;
    while (n < 40 && !obs_done) begin
      if (done_o) begin
        obs_done = 1'b1;
        obs_r = result_o; obs_hi = result_hi_o; obs_c = c_out_o; obs_z = z_out_o;
        obs_cld = c_ld_o; obs_zld = z_ld_o;
      end else begin
        if (interfere && n == 3) begin
          op = 4'd0; a = 8'h01; b = 8'h01; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    obs_lat = n;
    obs_ld_after = 1'b0;
    obs_extra = 0;
    if (!obs_done) chk("done_timeout", 0, 1);
    else begin
      @(negedge clk);
      obs_ld_after = c_ld_o | z_ld_o;
      // Watch a few idle cycles for a spurious second completion.
      repeat (12) begin
        if (done_o) obs_extra++;
        @(negedge clk);
      end
    end
    $display("txn op=%0d a=%02h b=%02h cin=%0d -> lat=%0d res=%02h hi=%02h c=%0d z=%0d ld=%0d",
             o, x, y, ci, obs_lat, obs_r, obs_hi, obs_c, obs_z, obs_cld);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t t;
    // Reset state.
    #1;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_result", int'(result_o), 0);
    chk("rst_c_ld", int'(c_ld_o), 0);
    chk("rst_c_out", int'(c_out_o), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Pin the model with hand-computed values.
    t = model(0, 8'hFF, 8'h01, 0);
    chk("model_add_r", int'(t.r), 8'h00);
    chk("model_add_c", int'(t.c), 1);
    t = model(3, 8'h10, 8'h10, 1);
    chk("model_subc_r", int'(t.r), 8'hFF);
    t = model(11, 8'h81, 0, 0);
    chk("model_asr_r", int'(t.r), 8'hC0);

    run_op(4'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
    chk("add_lat", obs_lat, 2);
    chk("add_r", int'(obs_r), 8'h00);
    chk("add_c", int'(obs_c), 1);
    chk("add_z", int'(obs_z), 1);
    chk("add_cld", int'(obs_cld), 1);
    chk("add_zld", int'(obs_zld), 1);
    chk("add_ld_after", int'(obs_ld_after), 0);

    run_op(4'd3, 8'h10, 8'h10, 1'b1, 1'b0);
    chk("subc_r", int'(obs_r), 8'hFF);
    chk("subc_c", int'(obs_c), 1);
    chk("subc_z", int'(obs_z), 0);

    run_op(4'd8, 8'h01, 8'h00, 1'b1, 1'b0);
    chk("lsr_r", int'(obs_r), 8'h80);
    chk("lsr_c", int'(obs_c), 1);

    run_op(4'd9, 8'h81, 8'h00, 1'b0, 1'b0);
    chk("rol_r", int'(obs_r), 8'h03);
    chk("rol_c", int'(obs_c), 1);

    run_op(4'd6, 8'h5A, 8'h5A, 1'b0, 1'b0);
    chk("xor_r", int'(obs_r), 8'h00);
    chk("xor_c", int'(obs_c), 0);
    chk("xor_z", int'(obs_z), 1);

    run_op(4'd12, 8'h10, 8'h10, 1'b0, 1'b1);
`ifdef MC_ALU_MUL_EN
    chk("mul_lat", obs_lat, W + 1);
    chk("mul_r", int'(obs_r), 8'h00);
    chk("mul_hi", int'(obs_hi), 8'h01);
    chk("mul_c", int'(obs_c), 1);
    chk("mul_z", int'(obs_z), 0);
    chk("mul_cld", int'(obs_cld), 1);
`else
    chk("mul_ill_lat", obs_lat, 2);
    chk("mul_ill_r", int'(obs_r), 8'h00);
    chk("mul_ill_hi", int'(obs_hi), 8'h00);
    chk("mul_ill_cld", int'(obs_cld), 0);
    chk("mul_ill_zld", int'(obs_zld), 0);
`endif
    chk("mul_single_done", obs_extra, 0);

    run_op(4'hF, 8'h33, 8'h44, 1'b1, 1'b0);
    chk("ill_lat", obs_lat, 2);
    chk("ill_r", int'(obs_r), 8'h00);
    chk("ill_cld", int'(obs_cld), 0);
    chk("ill_zld", int'(obs_zld), 0);

    run_op(4'd2, 8'h20, 8'h10, 1'b0, 1'b0);
    chk("sub_r", int'(obs_r), 8'h10);
    chk("sub_c", int'(obs_c), 0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = 4'd12; a = 8'h10; b = 8'h10; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_done", int'(done_o), 0);
    chk("arst_result", int'(result_o), 0);
    chk("arst_hi", int'(result_hi_o), 0);
    chk("arst_c_ld", int'(c_ld_o), 0);
    chk("arst_z_ld", int'(z_ld_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      chk("arst_no_done", int'(done_o), 0);
      @(negedge clk);
    end
    run_op(4'd0, 8'h02, 8'h03, 1'b0, 1'b0);
    chk("post_rst_add_r", int'(obs_r), 8'h05);
    chk("post_rst_add_c", int'(obs_c), 0);

    // Randomized traffic, including ignored starts while busy.
    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), W'($urandom_range(0, M - 1)),
             W'($urandom_range(0, M - 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
